// File: rtl/psum_accumulator_if.sv
// Bus between the tree-adder stage and the partial-sum accumulator.
interface psum_accumulator_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] psum_in;
  logic                  psum_valid_in;
  logic [7:0]            num_pass_in;
  logic [DATA_WIDTH-1:0] bias_in;
  logic                  relu_en_in;
  logic                  clear_in;
  logic [DATA_WIDTH-1:0] acc_out;
  logic                  acc_valid_out;
  logic                  busy_out;
  logic                  overflow_out;

  modport master (
    output psum_in, psum_valid_in, num_pass_in, bias_in, relu_en_in, clear_in,
    input  acc_out, acc_valid_out, busy_out, overflow_out
  );

  modport slave (
    input  psum_in, psum_valid_in, num_pass_in, bias_in, relu_en_in, clear_in,
    output acc_out, acc_valid_out, busy_out, overflow_out
  );
endinterface

// File: rtl/psum_accumulator.sv
// Accumulates num_pass signed partial sums, adds bias, optional ReLU,
// saturates to DATA_WIDTH and strobes the result; back-to-back groups allowed.
module psum_accumulator #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 32
) (
  input logic                clk,
  input logic                rst_n,
  psum_accumulator_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, FINISH} state_t;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  state_t                        state;
  logic signed [ACC_WIDTH-1:0]   acc;
  logic [7:0]                    pass_cnt;
  logic [7:0]                    num_pass_q;
  logic [DATA_WIDTH-1:0]         bias_q;
  logic                          relu_q;
  logic [DATA_WIDTH-1:0]         acc_q;
  logic                          acc_valid_q;
  logic                          overflow_q;

  logic signed [ACC_WIDTH-1:0]   psum_ext;
  logic signed [ACC_WIDTH-1:0]   bias_ext;
  logic signed [ACC_WIDTH-1:0]   sum;
  logic [DATA_WIDTH-1:0]         result;
  logic                          clip;
  logic [7:0]                    num_pass_eff;

  assign psum_ext     = {{(ACC_WIDTH-DATA_WIDTH){bus.psum_in[DATA_WIDTH-1]}}, bus.psum_in};
  assign bias_ext     = {{(ACC_WIDTH-DATA_WIDTH){bias_q[DATA_WIDTH-1]}}, bias_q};
  assign num_pass_eff = (bus.num_pass_in == 8'd0) ? 8'd1 : bus.num_pass_in;

  always_comb begin
    sum    = acc + bias_ext;
    clip   = 1'b0;
    if (relu_q && sum[ACC_WIDTH-1])
      sum = '0;
    result = sum[DATA_WIDTH-1:0];
    if (sum > SAT_MAX) begin
      result = SAT_MAX[DATA_WIDTH-1:0];
      clip   = 1'b1;
    end else if (sum < SAT_MIN) begin
      result = SAT_MIN[DATA_WIDTH-1:0];
      clip   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      pass_cnt    <= '0;
      num_pass_q  <= '0;
      bias_q      <= '0;
      relu_q      <= 1'b0;
      acc_q       <= '0;
      acc_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (bus.clear_in) begin
      state       <= IDLE;
      acc         <= '0;
      pass_cnt    <= '0;
      acc_valid_q <= 1'b0;
    end else begin
      acc_valid_q <= 1'b0;
      if (state == FINISH) begin
        acc_q       <= result;
        acc_valid_q <= 1'b1;
        overflow_q  <= overflow_q | clip;
      end
      // FINISH with a valid psum starts the next group in the same edge
      if (bus.psum_valid_in && (state == IDLE || state == FINISH)) begin
        acc        <= psum_ext;
        num_pass_q <= num_pass_eff;
        bias_q     <= bus.bias_in;
        relu_q     <= bus.relu_en_in;
        pass_cnt   <= 8'd1;
        state      <= (num_pass_eff == 8'd1) ? FINISH : ACCUM;
      end else if (bus.psum_valid_in && state == ACCUM) begin
        acc      <= acc + psum_ext;
        pass_cnt <= pass_cnt + 8'd1;
        if (pass_cnt + 8'd1 == num_pass_q)
          state <= FINISH;
      end else if (state == FINISH) begin
        state <= IDLE;
      end
    end
  end

  assign bus.acc_out       = acc_q;
  assign bus.acc_valid_out = acc_valid_q;
  assign bus.busy_out      = (state != IDLE);
  assign bus.overflow_out  = overflow_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed table-driven bench for psum_accumulator plus abort/reset/back-to-back sequences.
module tb_psum_accumulator;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  psum_accumulator_if #(.DATA_WIDTH(16)) bus ();

  psum_accumulator #(.DATA_WIDTH(16), .ACC_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish (got running, need finished)");
    $fatal(1, "timeout");
  end

  typedef struct {
    string            name;
    logic [7:0]       num_pass;
    int               bias;
    logic             relu;
    int               psums[4];
    int               gap;
    int               exp_acc;
    logic             exp_ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.psum_valid_in = 1'b0;
    bus.psum_in       = '0;
    bus.num_pass_in   = '0;
    bus.bias_in       = '0;
    bus.relu_en_in    = 1'b0;
    bus.clear_in      = 1'b0;
  endtask

  task automatic send(input int psum, input logic [7:0] np, input int bias, input logic relu);
    bus.psum_valid_in = 1'b1;
    bus.psum_in       = 16'(psum);
    bus.num_pass_in   = np;
    bus.bias_in       = 16'(bias);
    bus.relu_en_in    = relu;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    n = (v.num_pass == 8'd0) ? 1 : int'(v.num_pass);
    for (int k = 0; k < n; k++) begin
      send(v.psums[k], v.num_pass, v.bias, v.relu);
      step();
      bus.psum_valid_in = 1'b0;
      if (k != n - 1) begin
        check({v.name, " busy mid-group"}, int'(bus.busy_out), 1);
        for (int g = 0; g < v.gap; g++) begin
          step();
          check({v.name, " no strobe in gap"}, int'(bus.acc_valid_out), 0);
        end
      end
    end
    check({v.name, " no early strobe"}, int'(bus.acc_valid_out), 0);
    step();
    check({v.name, " strobe"}, int'(bus.acc_valid_out), 1);
    check({v.name, " acc_out"}, int'($signed(bus.acc_out)), v.exp_acc);
    check({v.name, " overflow"}, int'(bus.overflow_out), int'(v.exp_ovf));
    step();
    check({v.name, " single strobe"}, int'(bus.acc_valid_out), 0);
    check({v.name, " acc_out held"}, int'($signed(bus.acc_out)), v.exp_acc);
    check({v.name, " idle after"}, int'(bus.busy_out), 0);
  endtask

  initial begin
    vecs[0] = '{"basic",       8'd3,   10, 1'b0, '{100, 200, -50, 0},       0,    260, 1'b0};
    vecs[1] = '{"relu_neg",    8'd2,    3, 1'b1, '{-5, -5, 0, 0},           0,      0, 1'b0};
    vecs[2] = '{"gapped",      8'd3,   10, 1'b0, '{100, 200, -50, 0},       2,    260, 1'b0};
    vecs[3] = '{"np_zero",     8'd0,    1, 1'b0, '{5, 0, 0, 0},             0,      6, 1'b0};
    vecs[4] = '{"relu_pos",    8'd2,   -4, 1'b1, '{3, 4, 0, 0},             0,      3, 1'b0};
    vecs[5] = '{"max_edge",    8'd2,    1, 1'b0, '{32766, 0, 0, 0},         0,  32767, 1'b0};
    vecs[6] = '{"min_edge",    8'd1,   -1, 1'b0, '{-32767, 0, 0, 0},        0, -32768, 1'b0};
    vecs[7] = '{"sat_pos",     8'd2,    0, 1'b0, '{30000, 30000, 0, 0},     0,  32767, 1'b1};
    vecs[8] = '{"sat_neg",     8'd2, -100, 1'b0, '{-30000, -30000, 0, 0},   0, -32768, 1'b1};

    idle_inputs();
    rst_n = 1'b0;
    #12;
    check("reset acc_out",    int'(bus.acc_out), 0);
    check("reset acc_valid",  int'(bus.acc_valid_out), 0);
    check("reset busy",       int'(bus.busy_out), 0);
    check("reset overflow",   int'(bus.overflow_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 9; i++)
      run_vec(vecs[i]);

    // ReLU result with sticky overflow already set
    run_vec('{"relu_sticky", 8'd2, 3, 1'b1, '{-5, -5, 0, 0}, 0, 0, 1'b1});

    // back-to-back single-pass groups
    send(7, 8'd1, 0, 1'b0);
    step();
    send(9, 8'd1, 0, 1'b0);
    step();
    bus.psum_valid_in = 1'b0;
    check("b2b first strobe", int'(bus.acc_valid_out), 1);
    check("b2b first value",  int'($signed(bus.acc_out)), 7);
    check("b2b busy",         int'(bus.busy_out), 1);
    step();
    check("b2b second strobe", int'(bus.acc_valid_out), 1);
    check("b2b second value",  int'($signed(bus.acc_out)), 9);
    step();
    check("b2b end strobe", int'(bus.acc_valid_out), 0);

    // clear after 2 of 4
    send(1000, 8'd4, 0, 1'b0);
    step();
    send(1000, 8'd4, 0, 1'b0);
    step();
    bus.psum_valid_in = 1'b0;
    bus.clear_in = 1'b1;
    step();
    bus.clear_in = 1'b0;
    check("clear busy", int'(bus.busy_out), 0);
    check("clear overflow kept", int'(bus.overflow_out), 1);
    for (int c = 0; c < 3; c++) begin
      step();
      check("clear no strobe", int'(bus.acc_valid_out), 0);
    end
    run_vec('{"after_clear", 8'd1, 0, 1'b0, '{42, 0, 0, 0}, 0, 42, 1'b1});

    // clear wins over valid while a result is pending in FINISH
    send(3, 8'd1, 0, 1'b0);
    step();
    send(5, 8'd1, 0, 1'b0);
    bus.clear_in = 1'b1;
    step();
    idle_inputs();
    check("clear finish no strobe", int'(bus.acc_valid_out), 0);
    check("clear finish idle", int'(bus.busy_out), 0);
    step();
    check("clear finish still none", int'(bus.acc_valid_out), 0);
    check("clear finish acc held", int'($signed(bus.acc_out)), 42);

    // asynchronous reset after 2 of 4
    send(500, 8'd4, 0, 1'b0);
    step();
    send(500, 8'd4, 0, 1'b0);
    step();
    bus.psum_valid_in = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst busy",     int'(bus.busy_out), 0);
    check("async rst acc_out",  int'(bus.acc_out), 0);
    check("async rst overflow", int'(bus.overflow_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      check("rst no strobe", int'(bus.acc_valid_out), 0);
    end
    run_vec('{"after_rst", 8'd1, 0, 1'b0, '{42, 0, 0, 0}, 0, 42, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
